// File: rtl/arbiter3_rr_mutex.sv
// arbiter3_rr_mutex: 3-way round-robin mutex arbiter, break-before-make.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module arbiter3_rr_mutex #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       X2,
  input  logic       X1,
  input  logic       X0,
  output logic       Y2,
  output logic       Y1,
  output logic       Y0,
  output logic       busy,
  output logic [1:0] owner,
  output logic       tmo
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [2:0] x;
  logic [2:0] y;
  logic [1:0] p0, p1, p2;
  logic       win_vld;
  logic [1:0] win;
  logic       own_x;
  logic       hit;

  assign x  = {X2, X1, X0};
  assign Y2 = y[2];
  assign Y1 = y[1];
  assign Y0 = y[0];

  // Priority order starts just after the last owner.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (ptr)
      2'd0: begin
        p0 = 2'd1;
        p1 = 2'd2;
        p2 = 2'd0;
      end
      2'd1: begin
        p0 = 2'd2;
        p1 = 2'd0;
        p2 = 2'd1;
      end
      default: begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
      end
    endcase
  end

  // Pick the first active requester in rotated order.
  always_comb begin
    win_vld = |x;
    if (x[p0])
      win = p0;
    else if (x[p1])
      win = p1;
    else
      win = p2;
  end

  // Request line of the current owner.
  always_comb begin
    case (owner)
      2'd0:    own_x = x[0];
      2'd1:    own_x = x[1];
      2'd2:    own_x = x[2];
      default: own_x = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  logic [4:0] cnt;
  logic       tmo_q;

  assign hit = (state == S_GRANT) && (cnt == HOLD_LAST);
  assign tmo = tmo_q;

  // Count cycles the current grant has been held; zero outside GRANT.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 5'd0;
    else if (state == S_GRANT && own_x && !hit)
      cnt <= cnt + 5'd1;
    else
      cnt <= 5'd0;
  end

  // Pulse tmo for the gap cycle that follows a forced release.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_q <= 1'b0;
    else
      tmo_q <= hit;
  end
`else
  // Hold time is unlimited, so the bound is only kept for interface parity.
  logic unused_hold;
  assign unused_hold = ^MAX_HOLD;
  assign hit = 1'b0;
  assign tmo = 1'b0;
`endif

  // Arbitration FSM with registered grant, busy and owner outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= 2'd2;
      y     <= 3'b000;
      busy  <= 1'b0;
      owner <= 2'd3;
    end else begin
      case (state)
        S_GRANT: begin
          if (!own_x || hit) begin
            state <= S_GAP;
            y     <= 3'b000;
            busy  <= 1'b0;
            owner <= 2'd3;
          end
        end
        default: begin
          if (win_vld) begin
            state <= S_GRANT;
            ptr   <= win;
            y     <= 3'b001 << win;
            busy  <= 1'b1;
            owner <= win;
          end else begin
            state <= S_IDLE;
            y     <= 3'b000;
            busy  <= 1'b0;
            owner <= 2'd3;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/arbiter3_rr_mutex.md
ARBITER3_RR_MUTEX -- requirements
Module: arbiter3_rr_mutex

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one owner may hold a grant; legal range 2..31.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports X2, X1, X0, input, 1 bit each: request lines from requesters 2..0; 1 = requesting.
REQ-005 SHALL have ports Y2, Y1, Y0, output, 1 bit each: registered grant lines to requesters 2..0.
REQ-006 SHALL have port busy, output, 1 bit: registered; 1 whenever any Y is 1.
REQ-007 SHALL have port owner, output, 2 bits: registered index of the granted requester; 3 when no grant.
REQ-008 SHALL have port tmo, output, 1 bit: registered one-cycle pulse on forced release.

Function
REQ-009 SHALL keep at most one of Y2..Y0 at 1 in every cycle (mutual exclusion).
REQ-010 SHALL implement states IDLE, GRANT, GAP.
REQ-011 IDLE: all Y=0; if any X=1 at the edge, SHALL assert the winner's Y in the next cycle and go to GRANT; else stay IDLE.
REQ-012 Grant latency from request sampled in IDLE to Y=1 SHALL be exactly 1 cycle.
REQ-013 Winner SHALL be chosen round-robin from pointer ptr (last owner): priority ptr+1, ptr+2, ptr (mod 3).
REQ-014 ptr SHALL update to the winner's index at each new grant.
REQ-015 GRANT: owner's Y SHALL stay 1 while owner's X samples 1; requests from others SHALL be ignored (no preemption).
REQ-016 GRANT: when owner's X samples 0, Y SHALL go 0 in the next cycle and state SHALL go to GAP.
REQ-017 GAP SHALL last exactly one cycle with all Y=0 (break-before-make); at its edge SHALL arbitrate per REQ-013 into GRANT, or go to IDLE if no X=1.
REQ-018 Simultaneous requests SHALL be resolved only by REQ-013, never by fixed priority except after reset.
REQ-019 A requester dropping and reraising X within GAP SHALL compete normally; with ptr equal to its index it has lowest priority.
REQ-020 busy and owner SHALL change in the same cycle as Y.

Reset
REQ-021 With rst=1 at a rising edge, next cycle SHALL have Y2..Y0=0, busy=0, owner=3, tmo=0, state IDLE, ptr=2, hold counter 0.
REQ-022 rst SHALL dominate all other inputs, including mid-GRANT; no grant SHALL issue in the cycle following a reset edge.
REQ-023 After rst deasserts, first arbitration SHALL give X0 highest priority (ptr=2).

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL enable hold-timeout logic.
REQ-025 With ARB_TIMEOUT_EN defined: a 5-bit counter SHALL count GRANT cycles of the current owner; after the owner's Y has been 1 for MAX_HOLD cycles, Y SHALL go 0 in the next cycle, tmo SHALL pulse 1 for that one cycle, state SHALL go to GAP regardless of owner's X.
REQ-026 With ARB_TIMEOUT_EN defined: counter SHALL clear on every new grant and on reset.
REQ-027 Without ARB_TIMEOUT_EN: no counter SHALL be built, tmo SHALL be constant 0, grants SHALL be held indefinitely while X=1.

Verification
REQ-028 Reset then X2..X0=000 for 5 cycles -> Y=000, busy=0, owner=3 throughout.
REQ-029 After reset, X=111 held -> Y0=1 one cycle after first sample, owner=0; drop X0 -> one GAP cycle with Y=000, then Y1=1 owner=1; drop X1 -> GAP, then Y2=1 owner=2.
REQ-030 Owner 1 granted, X=011 applied, X0 stays 1 -> Y1 held, Y0 never 1 until X1 drops; after GAP Y0=1.
REQ-031 Owner 2 granted, X=110 -> rst pulsed 1 cycle mid-GRANT -> next cycle Y=000, owner=3; next arbitration with X=110 grants Y1.
REQ-032 ARB_TIMEOUT_EN defined, MAX_HOLD=4, X=101 held -> Y0 high 4 cycles, then Y=000 and tmo=1 for 1 cycle, then Y2=1 owner=2 for 4 cycles, then Y0 again.
REQ-033 All scenarios: checker SHALL flag any cycle with more than one Y=1 or busy inconsistent with Y.
